cnn_window_gen: RTL and testbench
=================================

Name: cnn_window_gen

Overview:
- Sliding-window generator. Feeds the cnn_kernel convolution core.
- Accepts a raster-ordered feature-map stream, one pixel per valid cycle.
- Buffers KH-1 image lines plus a KH x KW window register.
- Emits each full KW x KH window, packed in the layout the kernel consumes on its i_fmap/i_valid inputs.
- Convolution is "valid" only: no padding, stride 1.

Parameters:
- KW, 3, window width in pixels
- KH, 3, window height in pixels
- IF_BW, 8, pixel bit width
- IMG_W, 8, image width in pixels (must be >= KW)
- IMG_H, 8, image height in pixels (must be >= KH)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- i_valid  input  1  i_pixel is valid this cycle
- i_pixel  input  IF_BW  input pixel, raster order (row-major, left to right, top to bottom)
- o_fmap  output  KW*KH*IF_BW  window; slice m = r*KW + c at [m*IF_BW +: IF_BW], r=0 top row, c=0 leftmost column
- o_valid  output  1  o_fmap holds a new window this cycle (single-cycle pulse per window)
- o_last  output  1  asserted with o_valid for the final window of the frame

Behaviour:
- Clock and reset: single clock domain. All state updates on posedge clk. Reset is synchronous and active-high.
- Reset values:
  - o_valid=0, o_last=0, o_fmap=0.
  - Column counter col=0, row counter row=0.
  - Line-buffer RAM contents need not be cleared.
- Stall behaviour: cycles with i_valid=0 change no state. o_valid and o_last are 0 in those cycles. o_fmap holds its last value.
- Accepted pixel at position (row, col), i.e. a cycle with i_valid=1:
  - Line buffer j (j=0..KH-2) is an IMG_W-deep delay line. Line buffer 0 outputs the pixel at (row-1, col). Line buffer j outputs (row-1-j, col).
  - The window shifts one column left.
  - The new rightmost column c=KW-1 is loaded as follows: r=KH-1 takes i_pixel; r=KH-2-j takes the output of line buffer j.
  - Line buffers advance by one entry.
  - col increments. At col=IMG_W-1 it wraps to 0 and row increments. At row=IMG_H-1, col=IMG_W-1, both wrap to 0 (next pixel starts a new frame).
- Output timing:
  - Latency is 1 cycle. o_valid=1 in the cycle after accepting a pixel with row>=KH-1 and col>=KW-1.
  - In that cycle, o_fmap holds pixels rows row-KH+1..row, cols col-KW+1..col.
  - Windows never straddle a row boundary. Columns 0..KW-2 of each row produce no output.
- Windows per frame: (IMG_W-KW+1)*(IMG_H-KH+1).
- o_last: o_last=1 only together with the o_valid of the window whose trigger pixel is (IMG_H-1, IMG_W-1).
- Frame sequencing: back-to-back frames need no idle cycles. Stale line-buffer data is never emitted, because output is gated until row>=KH-1 of the new frame.
- Reset mid-frame:
  - Counters return to 0. o_valid and o_last drop on the next cycle.
  - The next accepted pixel is treated as (0,0) of a new frame.
- Backpressure: none. The downstream kernel accepts every cycle, matching its interface.
- Implementation: line buffers may be RAM or shift registers. Behaviour must be identical for IMG_W from KW up to 1024.

Test Plan:
1. IMG_W=IMG_H=4, KW=KH=3, continuous i_valid, pixels 1..16:
   - exactly 4 o_valid pulses;
   - first pulse is the cycle after pixel 11, o_fmap slices m0..m8 = 1,2,3,5,6,7,9,10,11;
   - last pulse has o_last=1, slices = 6,7,8,10,11,12,14,15,16.
2. Same frame with i_valid deasserted randomly about 50% of cycles: identical sequence of 4 windows and o_last; o_fmap stable while o_valid=0.
3. Two back-to-back frames, pixels 1..16 then 101..116:
   - 8 windows in total;
   - second frame's first window = 101,102,103,105,106,107,109,110,111 (no frame-1 data).
4. Reset asserted after pixel 7 of a frame, then a fresh frame 1..16: no output during or after reset until pixel 11 of the new frame; result matches scenario 1.
5. Default parameters (8x8), pixel value = row*8+col:
   - 36 windows;
   - window k (row-major) has m0 = (k/6)*8 + k%6 and m8 = m0 + 18;
   - o_last only on window 36.
6. Boundary IMG_W=KW=3, IMG_H=5, pixels 1..15:
   - one window per row from row 2 onward, 3 pulses;
   - first window = 1..9 in order.

Source files
------------

// File: rtl/cnn_window_gen.sv
// Sliding KW x KH window generator over a raster-ordered pixel stream.
// KH-1 column-addressed line buffers feed a KH x KW window register; windows are valid-only, stride 1.
module cnn_window_gen #(
  parameter int KW    = 3,
  parameter int KH    = 3,
  parameter int IF_BW = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [IF_BW-1:0]          i_pixel,
  output logic [KW*KH*IF_BW-1:0]    o_fmap,
  output logic                      o_valid,
  output logic                      o_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB = KH - 1;

  logic [CW-1:0]             col_r;
  logic [RW-1:0]             row_r;
  logic [IF_BW-1:0]          lb_r      [LB][IMG_W];
  logic [IF_BW-1:0]          lb_out_s  [LB];
  logic [IF_BW-1:0]          win_r     [KH][KW];
  logic [IF_BW-1:0]          win_nxt_s [KH][KW];
  logic [KW*KH*IF_BW-1:0]    fmap_nxt_s;
  logic                      col_end_s;
  logic                      row_end_s;
  logic                      emit_s;
  logic                      last_s;

  // Position decode and output qualification for the pixel on the input this cycle
  always_comb begin
    col_end_s = (col_r == CW'(IMG_W - 1));
    row_end_s = (row_r == RW'(IMG_H - 1));
    emit_s    = i_valid && (row_r >= RW'(KH - 1)) && (col_r >= CW'(KW - 1));
    last_s    = emit_s && col_end_s && row_end_s;
  end

  // Line buffer j read port: pixel (row-1-j, col) of the current frame once row > j
  always_comb begin
    for (int j = 0; j < LB; j++) begin
      lb_out_s[j] = lb_r[j][col_r];
    end
  end

  // Next window: shift left, load the new right column from the line buffers and i_pixel
  always_comb begin
    win_nxt_s = win_r;
    if (i_valid) begin
      for (int r = 0; r < KH; r++) begin
        for (int c = 0; c < KW - 1; c++) begin
          win_nxt_s[r][c] = win_r[r][c+1];
        end
      end
      win_nxt_s[KH-1][KW-1] = i_pixel;
      for (int j = 0; j < LB; j++) begin
        win_nxt_s[KH-2-j][KW-1] = lb_out_s[j];
      end
    end else begin
      win_nxt_s = win_r;
    end
  end

  // Pack the next window into the kernel layout, slice m = r*KW + c
  always_comb begin
    fmap_nxt_s = '0;
    for (int r = 0; r < KH; r++) begin
      for (int c = 0; c < KW; c++) begin
        fmap_nxt_s[(r*KW+c)*IF_BW +: IF_BW] = win_nxt_s[r][c];
      end
    end
  end

  // Line buffer storage; contents need no reset since output is gated by row
  always_ff @(posedge clk) begin
    if (i_valid && !rst) begin
      lb_r[0][col_r] <= i_pixel;
      for (int j = 1; j < LB; j++) begin
        lb_r[j][col_r] <= lb_out_s[j-1];
      end
    end
  end

  // Raster counters, window register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r   <= '0;
      row_r   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_fmap  <= '0;
      win_r   <= '{default: '0};
    end else begin
      o_valid <= emit_s;
      o_last  <= last_s;
      if (emit_s) begin
        o_fmap <= fmap_nxt_s;
      end
      if (i_valid) begin
        win_r <= win_nxt_s;
        if (col_end_s) begin
          col_r <= '0;
          row_r <= row_end_s ? '0 : row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: three geometries (4x4, 8x8, 3x5), reference windows
// computed from a stored copy of each frame and popped by a monitor on every o_valid.
module tb_cnn_window_gen;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid_a [N];
  logic [7:0]  i_pixel_a [N];
  logic [71:0] o_fmap_a  [N];
  logic        o_valid_a [N];
  logic        o_last_a  [N];

  int          img_w [N] = '{4, 8, 3};
  int          img_h [N] = '{4, 8, 5};
  logic [7:0]  img [N][8][8];
  int          cnt [N];
  logic [74:0] exp_q [$];
  logic [72:0] got_q [$];
  logic [74:0] mon_e;
  logic [71:0] prev [N];
  logic        rst_seen = 1'b1;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  cnn_window_gen #(.KW(3), .KH(3), .IF_BW(8), .IMG_W(4), .IMG_H(4)) u_4x4 (
    .clk(clk), .rst(rst), .i_valid(i_valid_a[0]), .i_pixel(i_pixel_a[0]),
    .o_fmap(o_fmap_a[0]), .o_valid(o_valid_a[0]), .o_last(o_last_a[0]));
  cnn_window_gen #(.KW(3), .KH(3), .IF_BW(8), .IMG_W(8), .IMG_H(8)) u_8x8 (
    .clk(clk), .rst(rst), .i_valid(i_valid_a[1]), .i_pixel(i_pixel_a[1]),
    .o_fmap(o_fmap_a[1]), .o_valid(o_valid_a[1]), .o_last(o_last_a[1]));
  cnn_window_gen #(.KW(3), .KH(3), .IF_BW(8), .IMG_W(3), .IMG_H(5)) u_3x5 (
    .clk(clk), .rst(rst), .i_valid(i_valid_a[2]), .i_pixel(i_pixel_a[2]),
    .o_fmap(o_fmap_a[2]), .o_valid(o_valid_a[2]), .o_last(o_last_a[2]));

  always @(posedge clk) rst_seen <= rst;

  // Reference: store the frame, emit the 3x3 window ending at each (r,c) with r,c >= 2
  task automatic model_accept(input int inst, input logic [7:0] p);
    int r, c;
    logic [71:0] f;
    logic lst;
    r = cnt[inst] / img_w[inst];
    c = cnt[inst] % img_w[inst];
    img[inst][r][c] = p;
    if (r >= 2 && c >= 2) begin
      f = '0;
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          f[(rr*3+cc)*8 +: 8] = img[inst][r-2+rr][c-2+cc];
      lst = (r == img_h[inst] - 1) && (c == img_w[inst] - 1);
      exp_q.push_back({2'(inst), lst, f});
    end
    cnt[inst] = (cnt[inst] + 1) % (img_w[inst] * img_h[inst]);
  endtask

  task automatic step(input int inst, input logic v, input logic [7:0] p, input logic r);
    @(negedge clk);
    rst = r;
    for (int k = 0; k < N; k++) begin
      i_valid_a[k] = 1'b0;
      i_pixel_a[k] = 8'($urandom);
    end
    i_valid_a[inst] = v;
    i_pixel_a[inst] = p;
    if (r) begin
      for (int k = 0; k < N; k++) cnt[k] = 0;
    end else if (v) begin
      model_accept(inst, p);
    end
  endtask

  task automatic send(input int inst, input logic [7:0] p, input int pct);
    while ($urandom_range(99) < pct) step(inst, 1'b0, 8'($urandom), 1'b0);
    step(inst, 1'b1, p, 1'b0);
  endtask

  task automatic flush(input int n);
    repeat (n) step(0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  function automatic logic [71:0] win_at(input int first, input int w);
    logic [71:0] v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r*3+c)*8 +: 8] = 8'(first + r*w + c);
    return v;
  endfunction

  // Monitor: pop one expectation per o_valid; between pulses o_last low and o_fmap held
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (o_valid_a[i]) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_window inst%0d: got %h last %0b required no pulse", i, o_fmap_a[i], o_last_a[i]);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e[74:73] != 2'(i) || mon_e[72] !== o_last_a[i] || mon_e[71:0] !== o_fmap_a[i]) begin
            fails++;
            $display("FAIL window inst%0d: got %h last %0b required inst%0d %h last %0b",
                     i, o_fmap_a[i], o_last_a[i], mon_e[74:73], mon_e[71:0], mon_e[72]);
          end
        end
        got_q.push_back({o_last_a[i], o_fmap_a[i]});
      end else begin
        tests++;
        if (o_last_a[i] !== 1'b0) begin
          fails++;
          $display("FAIL last_without_valid inst%0d: got %0b required 0", i, o_last_a[i]);
        end
        if (!rst_seen) begin
          tests++;
          if (o_fmap_a[i] !== prev[i]) begin
            fails++;
            $display("FAIL fmap_hold inst%0d: got %h required %h", i, o_fmap_a[i], prev[i]);
          end
        end
      end
      prev[i] = o_fmap_a[i];
    end
  end

  initial begin
    logic [72:0] g;
    for (int k = 0; k < N; k++) begin
      i_valid_a[k] = 1'b0;
      i_pixel_a[k] = 8'h00;
      prev[k] = '0;
      cnt[k] = 0;
    end
    repeat (3) step(0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < N; k++) begin
      check("reset_valid", 72'(o_valid_a[k]), 72'd0);
      check("reset_last", 72'(o_last_a[k]), 72'd0);
      check("reset_fmap", o_fmap_a[k], 72'd0);
    end
    flush(2);

    // 1: 4x4 continuous
    got_q.delete();
    for (int p = 1; p <= 16; p++) send(0, 8'(p), 0);
    flush(3);
    check("s1_count", 72'(got_q.size()), 72'd4);
    if (got_q.size() == 4) begin
      g = got_q[0];
      check("s1_first", g[71:0], win_at(1, 4));
      check("s1_first_last", 72'(g[72]), 72'd0);
      g = got_q[3];
      check("s1_final", g[71:0], win_at(6, 4));
      check("s1_final_last", 72'(g[72]), 72'd1);
    end

    // 2: same frame with ~50% idle cycles
    got_q.delete();
    for (int p = 1; p <= 16; p++) send(0, 8'(p), 50);
    flush(3);
    check("s2_count", 72'(got_q.size()), 72'd4);

    // 3: back-to-back frames
    got_q.delete();
    for (int p = 1; p <= 16; p++) send(0, 8'(p), 0);
    for (int p = 101; p <= 116; p++) send(0, 8'(p), 0);
    flush(3);
    check("s3_count", 72'(got_q.size()), 72'd8);
    if (got_q.size() == 8) begin
      g = got_q[4];
      check("s3_frame2_first", g[71:0], win_at(101, 4));
    end

    // 4: reset after pixel 7, then a fresh frame
    got_q.delete();
    for (int p = 1; p <= 7; p++) send(0, 8'(p), 0);
    step(0, 1'b1, 8'h55, 1'b1);
    step(0, 1'b1, 8'haa, 1'b1);
    for (int p = 1; p <= 16; p++) send(0, 8'(p), 0);
    flush(3);
    check("s4_count", 72'(got_q.size()), 72'd4);
    if (got_q.size() == 4) begin
      g = got_q[0];
      check("s4_first", g[71:0], win_at(1, 4));
    end

    // 5: 8x8, pixel = row*8+col, random gaps
    got_q.delete();
    for (int p = 0; p < 64; p++) send(1, 8'(p), 30);
    flush(3);
    check("s5_count", 72'(got_q.size()), 72'd36);
    if (got_q.size() == 36) begin
      for (int k = 0; k < 36; k++) begin
        g = got_q[k];
        check("s5_m0", 72'(g[7:0]), 72'((k/6)*8 + k%6));
        check("s5_m8", 72'(g[71:64]), 72'((k/6)*8 + k%6 + 18));
        check("s5_last", 72'(g[72]), 72'(k == 35));
      end
    end

    // 6: IMG_W = KW = 3, IMG_H = 5
    got_q.delete();
    for (int p = 1; p <= 15; p++) send(2, 8'(p), 20);
    flush(3);
    check("s6_count", 72'(got_q.size()), 72'd3);
    if (got_q.size() == 3) begin
      g = got_q[0];
      check("s6_first", g[71:0], win_at(1, 3));
      g = got_q[2];
      check("s6_final_last", 72'(g[72]), 72'd1);
    end

    check("scoreboard_drained", 72'(exp_q.size()), 72'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
